// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and responder FSM state type.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StErr1,
      StErr2
   } slv_state_e;

   // The only hsize accepted is the full data-bus width.
   function automatic logic [2:0] legal_hsize(input int unsigned dw);
      return 3'($clog2(dw / 8));
   endfunction

endpackage

// File: rtl/ahb_slave_regfile.sv
// Word storage for the AHB responder: synchronous write/clear, combinational read.
module ahb_slave_regfile #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned ADDRWIDTH = 6,
   parameter int unsigned DEPTH     = 48
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [ADDRWIDTH-1:0] waddr,
   input  logic [DATAWIDTH-1:0] wdata,
   input  logic [ADDRWIDTH-1:0] raddr,
   output logic [DATAWIDTH-1:0] rdata
);

   logic [DATAWIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (we && (32'(waddr) < DEPTH)) begin
         mem[waddr] <= wdata;
      end
   end

   // Out-of-range reads never reach the array; they read as zero.
   always_comb begin
      rdata = '0;
      if (32'(raddr) < DEPTH) begin
         rdata = mem[raddr];
      end
   end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder with local word memory, configurable wait states and
// two-cycle ERROR responses for out-of-range addresses or illegal sizes.
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int unsigned DATAWIDTH   = 16,
   parameter int unsigned ADDRWIDTH   = 6,
   parameter int unsigned DEPTH       = 48,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                 hclk,
   input  logic                 hrst,
   input  logic                 hsel,
   input  logic [ADDRWIDTH-1:0] haddr,
   input  logic [1:0]           htrans,
   input  logic                 hwrite,
   input  logic [2:0]           hsize,
   input  logic [DATAWIDTH-1:0] hwdata,
   input  logic                 hreadyin,
   output logic                 hready,
   output logic                 hresp,
   output logic [DATAWIDTH-1:0] hrdata
);

   localparam int unsigned CntW      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [2:0]  LegalSize = legal_hsize(DATAWIDTH);

   slv_state_e           state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [ADDRWIDTH-1:0] addr_q, addr_d;
   logic                 write_q, write_d;
   logic                 dphase_q, dphase_d;

   logic                 accept;
   logic                 err_in;
   logic                 mem_we;
   logic [DATAWIDTH-1:0] mem_rdata;

   // Gating on our own hready keeps a stalled bus from slipping in a capture.
   assign accept = hsel & hreadyin & htrans[1] & hready;
   assign err_in = (32'(haddr) >= DEPTH) | (hsize != LegalSize);

   always_ff @(posedge hclk) begin
      if (hrst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         dphase_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         dphase_q <= dphase_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      write_d  = write_q;
      dphase_d = dphase_q;

      unique case (state_q)
         StIdle, StErr2: begin
            state_d = StIdle;
            if (accept) begin
               if (err_in) begin
                  state_d = StErr1;
               end else if (WAIT_STATES > 0) begin
                  state_d = StWait;
                  cnt_d   = CntW'(WAIT_STATES);
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q <= CntW'(1)) begin
               state_d = StIdle;
            end
         end
         StErr1: state_d = StErr2;
         default: state_d = StIdle;
      endcase

      // dphase marks an OKAY data phase in flight; it ends on the hready=1 cycle.
      if (accept) begin
         addr_d   = haddr;
         write_d  = hwrite;
         dphase_d = ~err_in;
      end else if (hready) begin
         dphase_d = 1'b0;
      end
   end

   always_comb begin
      hready = 1'b1;
      hresp  = HRESP_OKAY;
      unique case (state_q)
         StIdle: begin
            hready = 1'b1;
            hresp  = HRESP_OKAY;
         end
         StWait: begin
            hready = 1'b0;
            hresp  = HRESP_OKAY;
         end
         StErr1: begin
            hready = 1'b0;
            hresp  = HRESP_ERROR;
         end
         StErr2: begin
            hready = 1'b1;
            hresp  = HRESP_ERROR;
         end
         default: begin
            hready = 1'b1;
            hresp  = HRESP_OKAY;
         end
      endcase
   end

   always_comb begin
      mem_we = dphase_q & write_q & (state_q == StIdle);
      hrdata = '0;
      if (dphase_q && !write_q && (state_q == StIdle)) begin
         hrdata = mem_rdata;
      end
   end

   ahb_slave_regfile #(
      .DATAWIDTH (DATAWIDTH),
      .ADDRWIDTH (ADDRWIDTH),
      .DEPTH     (DEPTH)
   ) u_regfile (
      .clk   (hclk),
      .rst   (hrst),
      .we    (mem_we),
      .waddr (addr_q),
      .wdata (hwdata),
      .raddr (addr_q),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench: one responder with a wait state, one zero-wait for bursts.
module tb_ahb_slave_mem;
   import ahb_pkg::*;

   localparam int WS = 1;

   logic        hclk = 1'b0;
   logic        hrst;
   logic        hsel_a, hsel_b;
   logic [5:0]  haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [15:0] hwdata;
   logic        block_a;
   logic        hreadyin_a, hreadyin_b;
   logic        hready_a, hresp_a, hready_b, hresp_b;
   logic [15:0] hrdata_a, hrdata_b;

   typedef struct {
      logic        err;
      logic [15:0] rd;
      int          waits;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 hclk = ~hclk;

   assign hreadyin_a = hready_a & ~block_a;
   assign hreadyin_b = hready_b;

   ahb_slave_mem #(
      .DATAWIDTH(16), .ADDRWIDTH(6), .DEPTH(48), .WAIT_STATES(WS)
   ) dut (
      .hclk(hclk), .hrst(hrst), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin_a),
      .hready(hready_a), .hresp(hresp_a), .hrdata(hrdata_a)
   );

   ahb_slave_mem #(
      .DATAWIDTH(16), .ADDRWIDTH(6), .DEPTH(48), .WAIT_STATES(0)
   ) dut0 (
      .hclk(hclk), .hrst(hrst), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin_b),
      .hready(hready_b), .hresp(hresp_b), .hrdata(hrdata_b)
   );

   // Single transfer on dut; entered and left at a negedge.
   task automatic xfer(input logic wr, input logic [5:0] a, input logic [15:0] d,
                       input logic [2:0] sz, input logic exp_err, input logic [15:0] exp_rd,
                       input string nm);
      exp_t e;
      int   n;
      logic done;
      exp_q.push_back('{err: exp_err, rd: (wr || exp_err) ? 16'h0 : exp_rd,
                        waits: exp_err ? 1 : WS});
      hsel_a = 1'b1; haddr = a; htrans = HTRANS_NONSEQ; hwrite = wr; hsize = sz;
      @(posedge hclk); #1;
      hsel_a = 1'b0; htrans = HTRANS_IDLE; hwdata = d;
      n = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge hclk);
         if (!hready_a) begin
            n++;
            total++;
            if (hresp_a !== exp_err) begin
               bad++;
               $display("FAIL %s wait_hresp got=%b want=%b", nm, hresp_a, exp_err);
            end
         end else begin
            done = 1'b1;
         end
      end
      total++;
      if (!done || exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s timeout got=no_hready want=hready", nm);
      end else begin
         e = exp_q.pop_front();
         total += 3;
         if (hresp_a !== e.err) begin
            bad++;
            $display("FAIL %s hresp got=%b want=%b", nm, hresp_a, e.err);
         end
         if (hrdata_a !== e.rd) begin
            bad++;
            $display("FAIL %s hrdata got=%h want=%h", nm, hrdata_a, e.rd);
         end
         if (n != e.waits) begin
            bad++;
            $display("FAIL %s waits got=%0d want=%0d", nm, n, e.waits);
         end
      end
   endtask

   task automatic test_reset();
      hrst = 1'b1; hsel_a = 1'b0; hsel_b = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
      hwrite = 1'b0; hsize = HSIZE_HALF; hwdata = '0; block_a = 1'b0;
      repeat (2) @(posedge hclk);
      #1 hrst = 1'b0;
      @(negedge hclk);
      total += 3;
      if (hready_a !== 1'b1) begin
         bad++; $display("FAIL reset_hready got=%b want=1", hready_a);
      end
      if (hresp_a !== 1'b0) begin
         bad++; $display("FAIL reset_hresp got=%b want=0", hresp_a);
      end
      if (hrdata_a !== 16'h0) begin
         bad++; $display("FAIL reset_hrdata got=%h want=0000", hrdata_a);
      end
      xfer(1'b0, 6'd5, 16'h0, HSIZE_HALF, 1'b0, 16'h0000, "reset_rd5");
   endtask

   task automatic test_write_read();
      xfer(1'b1, 6'd3, 16'hA5A5, HSIZE_HALF, 1'b0, 16'h0, "wr3");
      xfer(1'b0, 6'd3, 16'h0, HSIZE_HALF, 1'b0, 16'hA5A5, "rd3");
      xfer(1'b1, 6'd47, 16'h5A3C, HSIZE_HALF, 1'b0, 16'h0, "wr47");
      xfer(1'b0, 6'd47, 16'h0, HSIZE_HALF, 1'b0, 16'h5A3C, "rd47");
   endtask

   task automatic test_out_of_range();
      xfer(1'b1, 6'd50, 16'h1234, HSIZE_HALF, 1'b1, 16'h0, "wr50_err");
      xfer(1'b0, 6'd50, 16'h0, HSIZE_HALF, 1'b1, 16'h0, "rd50_err");
      xfer(1'b1, 6'd48, 16'h7777, HSIZE_HALF, 1'b1, 16'h0, "wr48_err");
      xfer(1'b0, 6'd47, 16'h0, HSIZE_HALF, 1'b0, 16'h5A3C, "rd47_after_err");
   endtask

   task automatic test_illegal_size();
      xfer(1'b1, 6'd2, 16'hBEEF, HSIZE_HALF, 1'b0, 16'h0, "wr2");
      xfer(1'b0, 6'd2, 16'h0, HSIZE_BYTE, 1'b1, 16'h0, "rd2_byte_err");
      xfer(1'b1, 6'd2, 16'h1111, HSIZE_WORD, 1'b1, 16'h0, "wr2_word_err");
      xfer(1'b0, 6'd2, 16'h0, HSIZE_HALF, 1'b0, 16'hBEEF, "rd2_ok");
   endtask

   // Pipelined zero-wait burst on dut0: writes 0..3 then reads 0..3.
   task automatic test_back_to_back();
      exp_t e;
      hsel_b = 1'b1; haddr = 6'd0; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_HALF;
      exp_q.push_back('{err: 1'b0, rd: 16'h0, waits: 0});
      for (int k = 1; k <= 8; k++) begin
         @(posedge hclk); #1;
         hwdata = (k <= 4) ? 16'(k) : 16'h0;
         if (k < 8) begin
            haddr  = 6'(k % 4);
            hwrite = (k < 4);
            htrans = (k == 4) ? HTRANS_NONSEQ : HTRANS_SEQ;
            exp_q.push_back('{err: 1'b0, rd: (k < 4) ? 16'h0 : 16'((k % 4) + 1), waits: 0});
         end else begin
            hsel_b = 1'b0; htrans = HTRANS_IDLE;
         end
         @(negedge hclk);
         total++;
         if (exp_q.size() == 0) begin
            bad++; $display("FAIL burst_%0d queue got=empty want=entry", k);
         end else begin
            e = exp_q.pop_front();
            total += 2;
            if (hready_b !== 1'b1 || hresp_b !== e.err) begin
               bad++;
               $display("FAIL burst_%0d hready/hresp got=%b/%b want=1/%b",
                        k, hready_b, hresp_b, e.err);
            end
            if (hrdata_b !== e.rd) begin
               bad++; $display("FAIL burst_%0d hrdata got=%h want=%h", k, hrdata_b, e.rd);
            end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      hsel_a = 1'b1; haddr = 6'd7; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_HALF;
      @(posedge hclk); #1;
      hsel_a = 1'b0; htrans = HTRANS_IDLE; hwdata = 16'hFFFF;
      @(negedge hclk);
      total++;
      if (hready_a !== 1'b0) begin
         bad++; $display("FAIL midwr_wait hready got=%b want=0", hready_a);
      end
      hrst = 1'b1;
      @(posedge hclk); #1;
      hrst = 1'b0;
      @(negedge hclk);
      total += 2;
      if (hready_a !== 1'b1) begin
         bad++; $display("FAIL midwr_after_rst hready got=%b want=1", hready_a);
      end
      if (hresp_a !== 1'b0) begin
         bad++; $display("FAIL midwr_after_rst hresp got=%b want=0", hresp_a);
      end
      @(negedge hclk);
      xfer(1'b0, 6'd7, 16'h0, HSIZE_HALF, 1'b0, 16'h0000, "rd7_after_rst");
      xfer(1'b0, 6'd3, 16'h0, HSIZE_HALF, 1'b0, 16'h0000, "rd3_cleared");
      // A NONSEQ with hreadyin low must be ignored entirely.
      block_a = 1'b1;
      hsel_a = 1'b1; haddr = 6'd9; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
      @(posedge hclk); #1;
      block_a = 1'b0; hsel_a = 1'b0; htrans = HTRANS_IDLE; hwdata = 16'h5555;
      @(negedge hclk);
      total++;
      if (hready_a !== 1'b1) begin
         bad++; $display("FAIL blocked_accept hready got=%b want=1", hready_a);
      end
      repeat (3) @(negedge hclk);
      xfer(1'b0, 6'd9, 16'h0, HSIZE_HALF, 1'b0, 16'h0000, "rd9_blocked");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_out_of_range();
      test_illegal_size();
      test_back_to_back();
      test_reset_mid_write();
      repeat (2) @(negedge hclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite responder (slave) that terminates the bus driven by the socket's master side and stores data in a local word-addressed memory.
- Decodes address-phase signals and inserts a configurable number of wait states.
- Returns OKAY/ERROR responses and read data in the pipelined data phase.
- Sits behind the socket's address decoder, paired one-to-one with the master.

Parameters:
DATAWIDTH, 16, hwdata/hrdata width in bits; power of two, >= 8
ADDRWIDTH, 6, haddr width; word address, not byte address
DEPTH, 48, implemented words; any haddr >= DEPTH gets an ERROR response
WAIT_STATES, 1, wait cycles (hready low) inserted in every OKAY data phase; 0 means zero-wait

Ports:
hclk  input  1  bus clock; all logic on rising edge
hrst  input  1  synchronous reset, active-high
hsel  input  1  slave select from decoder
haddr  input  ADDRWIDTH  word address (address phase)
htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hwrite  input  1  1=write, 0=read (address phase)
hsize  input  3  transfer size; only log2(DATAWIDTH/8) is legal (001 for 16 bit)
hwdata  input  DATAWIDTH  write data (data phase)
hreadyin  input  1  bus-level hready; address phase is valid only when high
hready  output  1  transfer-done / wait-state indication
hresp  output  1  0=OKAY, 1=ERROR
hrdata  output  DATAWIDTH  read data; valid when hready=1 in a read data phase

Behaviour:
- Reset (hrst=1 at a clock edge): state=IDLE, hready=1, hresp=0, hrdata=0, wait counter=0, all DEPTH memory words=0, captured address-phase registers cleared. Reset wins over any in-flight transfer; a pending write is discarded.
- Accept: a transfer is accepted at an edge where hsel & hreadyin & htrans[1]. At that edge, register haddr, hwrite and err = (haddr >= DEPTH) | (hsize != legal).
- IDLE/BUSY, or hsel=0: no transfer. The next data phase is OKAY with zero waits (hready=1, hresp=0).
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hready=1, hresp=0. On an accepted transfer: if err go to ERR1; else if WAIT_STATES>0 go to WAIT and load counter=WAIT_STATES; else stay in IDLE, since the data phase completes in the next cycle with hready=1.
  - WAIT: hready=0, hresp=0, counter decrements each cycle. When counter reaches 1, next state is DATA-complete: return to IDLE with hready=1 for exactly one cycle. Total data phase = WAIT_STATES+1 cycles.
  - ERR1: hready=0, hresp=1. Next state is ERR2.
  - ERR2: hready=1, hresp=1. Next state is IDLE.
  - The standard two-cycle ERROR response applies. A new address phase presented during ERR2 is accepted normally.
- Write commit: mem[addr_q] <= hwdata at the edge ending an OKAY write data phase (hready=1). Writes with an ERROR response never modify memory.
- Read: hrdata = mem[addr_q] combinationally during an OKAY read data phase. Otherwise hrdata=0, including during ERROR responses, writes and idle cycles.
- Back-to-back: a write to address A immediately followed by a read of A returns the new data, because the commit precedes the read's data phase.
- Pipelining: the address phase of transfer N+1 overlaps the data phase of N. Capture occurs only when hreadyin=1, so the slave's own wait states stall the bus.
- No byte lanes: narrow hsize always gets ERROR.
- Wait counter width: $clog2(WAIT_STATES+1), minimum 1.

Decomposition:
- Shared package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, HSIZE_BYTE/HALF/WORD, slave FSM state encoding.
- One sub-module, ahb_slave_regfile: DEPTH x DATAWIDTH array with synchronous write enable, combinational read, synchronous clear on hrst.
- FSM, wait counter and address-phase capture stay in ahb_slave_mem.

Test Plan:
- Reset: hold hrst for 2 cycles -> hready=1, hresp=0, hrdata=0; a read of addr 5 returns 0x0000.
- WAIT_STATES=1: NONSEQ write addr 0x03 data 0xA5A5, then NONSEQ read addr 0x03 -> write data phase shows hready 0 then 1; read data phase shows hready 0 then 1 with hrdata=0xA5A5, hresp=0.
- Out of range, DEPTH=48: write haddr=50 data 0x1234 -> ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1); a later read of addr 50 also errors and hrdata stays 0.
- Illegal size: read with hsize=000 at addr 2 -> two-cycle ERROR; then a legal read of addr 2 returns its stored value OKAY.
- WAIT_STATES=0 burst: SEQ writes to addrs 0..3 with 0x0001..0x0004, then reads -> hready constantly 1, data returned 0x0001..0x0004 in consecutive cycles.
- Reset mid-write: assert hrst during the WAIT cycle of a write to addr 7 with 0xFFFF -> hready=1 next cycle; a read of addr 7 returns 0x0000; hreadyin=0 with htrans=NONSEQ is never accepted.
